// File: rtl/keypad_pkg.sv
// Shared types and sizes for the keypad encoder slice.
package keypad_pkg;

    localparam int KEY_COUNT = 10;
    localparam int CODE_W    = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_QUALIFY      = 2'd1,
        ST_HOLD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

endpackage : keypad_pkg

// File: rtl/onehot_priority_enc.sv
// Lowest-set-bit index of the key vector plus any/multi-bit flags; purely combinational.
import keypad_pkg::*;

module onehot_priority_enc (
    input  logic [KEY_COUNT-1:0] vec,
    output logic [CODE_W-1:0]    idx,
    output logic                 any,
    output logic                 multi
);

    // Scan downwards so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - KEY_COUNT'(1)));

endmodule : onehot_priority_enc

// File: rtl/keypad_encoder.sv
// Qualifies a stable key vector for STABLE_CYCLES samples and hands its BCD code to a
// ready/valid consumer. Multi-key handling selected by macro KEYPAD_MULTI_ERR_EN.
//
// state           | meaning
// ST_IDLE         | no key pressed, waiting for a press
// ST_QUALIFY      | counting consecutive identical samples
// ST_HOLD         | code presented, waiting for ready
// ST_WAIT_RELEASE | code consumed or rejected, waiting for all keys released
import keypad_pkg::*;

module keypad_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [KEY_COUNT-1:0] keys,
    input  logic                 ready,
    output logic                 valid,
    output logic [CODE_W-1:0]    code,
    output logic                 err
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    state_t               state;
    state_t               state_d;
    logic [KEY_COUNT-1:0] sample;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_d;
    logic                 sample_ld;
    logic                 qual_hit;
    logic                 key_any;
    logic                 key_multi;
    logic [CODE_W-1:0]    key_idx;
    logic                 valid_d;
    logic [CODE_W-1:0]    code_d;

    onehot_priority_enc u_enc (
        .vec   (keys),
        .idx   (key_idx),
        .any   (key_any),
        .multi (key_multi)
    );

    // Qualification datapath: at the qualifying edge keys equals sample, so the
    // encoder can look at keys directly.
    always_comb begin
        cnt_d     = cnt;
        sample_ld = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_any) begin
                    sample_ld = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_QUALIFY: begin
                if (!key_any) begin
                    cnt_d = '0;
                end else if (keys != sample) begin
                    sample_ld = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else if (cnt >= STABLE_CNT) begin
                    cnt_d = STABLE_CNT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        qual_hit = key_any && (state == ST_IDLE || state == ST_QUALIFY) && (cnt_d == STABLE_CNT);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt    <= '0;
            sample <= '0;
        end else begin
            cnt <= cnt_d;
            if (sample_ld) begin
                sample <= keys;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (key_any) begin
                    state_d = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!key_any) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    state_d = key_any ? ST_WAIT_RELEASE : ST_IDLE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!key_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (qual_hit) begin
`ifdef KEYPAD_MULTI_ERR_EN
            state_d = key_multi ? ST_WAIT_RELEASE : ST_HOLD;
`else
            state_d = ST_HOLD;
`endif
        end
    end

`ifdef KEYPAD_MULTI_ERR_EN
    logic err_d;
`else
    logic unused_multi;
    assign unused_multi = key_multi;
`endif

    always_comb begin
        valid_d = valid;
        code_d  = code;
`ifdef KEYPAD_MULTI_ERR_EN
        err_d   = 1'b0;
`endif
        if (qual_hit) begin
`ifdef KEYPAD_MULTI_ERR_EN
            if (key_multi) begin
                err_d   = 1'b1;
                valid_d = 1'b0;
                code_d  = '0;
            end else begin
                valid_d = 1'b1;
                code_d  = key_idx;
            end
`else
            valid_d = 1'b1;
            code_d  = key_idx;
`endif
        end else if (state == ST_HOLD && ready) begin
            valid_d = 1'b0;
            code_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid <= 1'b0;
            code  <= '0;
        end else begin
            valid <= valid_d;
            code  <= code_d;
        end
    end

`ifdef KEYPAD_MULTI_ERR_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule : keypad_encoder

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a key vector is accepted; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 keys  input  10  debounced key levels; bit i high = digit key i pressed.
REQ-005 ready  input  1  consumer accepts code this cycle.
REQ-006 valid  output  1  code holds an accepted digit.
REQ-007 code  output  4  BCD digit 0..9 of accepted key.
REQ-008 err  output  1  one-cycle pulse: multi-key press rejected (config dependent).

Function
REQ-009 The FSM SHALL have states IDLE, QUALIFY, HOLD, WAIT_RELEASE.
REQ-010 IDLE: keys==0 -> stay; keys!=0 -> QUALIFY, capture keys into sample register, count=1.
REQ-011 QUALIFY: keys==0 -> IDLE; keys!=sample -> recapture, count=1; keys==sample -> count+1, saturating at STABLE_CYCLES.
REQ-012 QUALIFY, at the edge where count reaches STABLE_CYCLES: single-bit sample -> HOLD with valid=1, code=bit index; multi-bit sample -> per REQ-020/021.
REQ-013 With a constant single-key vector present before edge 0, valid SHALL be high after edge STABLE_CYCLES-1 (count=1 at edge 0); STABLE_CYCLES=1 gives valid after edge 0.
REQ-014 HOLD: valid and code SHALL stay constant while ready=0, regardless of keys.
REQ-015 HOLD with ready=1 at a rising edge: transfer completes; valid=0 next cycle; keys!=0 -> WAIT_RELEASE, keys==0 -> IDLE.
REQ-016 WAIT_RELEASE: keys==0 -> IDLE; otherwise stay; a held key SHALL never generate a second valid.
REQ-017 ready while valid=0 SHALL be ignored.
REQ-018 Counter width SHALL be 4 bits; no wrap-around, saturates.
REQ-019 code SHALL be 4'd0 whenever valid=0.
REQ-020 KEYPAD_MULTI_ERR_EN defined: multi-bit sample qualified -> err=1 for exactly one cycle, valid stays 0, next state WAIT_RELEASE.
REQ-021 KEYPAD_MULTI_ERR_EN undefined: multi-bit sample -> lowest set index encoded, treated as single key; err tied 0.

Reset
REQ-022 clr_n low SHALL immediately force state=IDLE, valid=0, code=0, err=0, count=0, sample=0, independent of clk.
REQ-023 Reset asserted mid-QUALIFY or mid-HOLD SHALL discard pending code; no transfer completes after release.
REQ-024 After clr_n rises, a key already held SHALL be processed from IDLE as a new press.

Configuration
REQ-025 Macro KEYPAD_MULTI_ERR_EN SHALL select multi-key behaviour per REQ-020 (defined) or REQ-021 (undefined); port list identical in both builds.

Structure
REQ-026 Package keypad_pkg SHALL hold state enumeration, KEY_COUNT=10, CODE_W=4, CNT_W=4.
REQ-027 Sub-module onehot_priority_enc SHALL convert 10-bit vector to lowest-set index plus multi-bit flag, purely combinational.
REQ-028 Total RTL SHALL stay within one FSM, one counter, one sample register, one output register.

Verification
REQ-029 STABLE_CYCLES=4, keys=10'b0000000100 held, ready=0 -> valid=1, code=2 after edge 3; stays until ready=1; valid=0 next cycle.
REQ-030 keys=bit5 for 2 cycles then bit7 held -> counter restarts; valid with code=7 only after 4 stable edges of bit7.
REQ-031 Key 3 held through transfer and 20 further cycles -> exactly one valid; WAIT_RELEASE until keys=0, then IDLE.
REQ-032 keys=bit1|bit4 held 4 cycles -> with KEYPAD_MULTI_ERR_EN: err pulse 1 cycle, no valid; without: valid, code=1, err=0.
REQ-033 clr_n pulsed low during HOLD (code=9, ready=0) -> valid, code drop to 0 asynchronously; with key 9 still held after release, new valid after 4 edges.
REQ-034 Key released during QUALIFY after 2 edges -> return to IDLE, valid never asserted.
